// File: rtl/rf_scoreboard_if.sv
// rf_scoreboard_if
// Groups the register-file bus between the datapath and rf_scoreboard.
// Parameters must match the rf_scoreboard instance the interface is bound to.
//   ra       : NUM_R packed read addresses (port k = ra[k*ADDR_W +: ADDR_W])
//   rd       : NUM_R packed read data      (port k = rd[k*DATA_W +: DATA_W])
//   rd_busy  : per-port pending flag of the addressed register
//   we/wa/wd : writeback port (clears pending on the written register)
//   rsv/rsv_a: reservation port (marks a register pending from decode)
//   busy_any : OR of all pending bits
// The master modport is the datapath side; the slave modport is the register file.
interface rf_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_R  = 2
);

  logic [NUM_R*ADDR_W-1:0] ra;
  logic [NUM_R*DATA_W-1:0] rd;
  logic [NUM_R-1:0]        rd_busy;
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [DATA_W-1:0]       wd;
  logic                    rsv;
  logic [ADDR_W-1:0]       rsv_a;
  logic                    busy_any;

  modport master (
    output ra, we, wa, wd, rsv, rsv_a,
    input  rd, rd_busy, busy_any
  );

  modport slave (
    input  ra, we, wa, wd, rsv, rsv_a,
    output rd, rd_busy, busy_any
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Multi-ported register file with a per-register pending (scoreboard) bit.
// Writes and reservations take effect on the rising clock edge; reads are
// combinational, with optional same-cycle bypass of the write port and an
// optional hardwired zero register.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears all data and pending bits
//   bus   : rf_scoreboard_if slave modport (read, write, reserve, busy status)
module rf_scoreboard #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NUM_R         = 2,
  parameter int ZERO_REG      = 1,
  parameter int WRITE_THROUGH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_scoreboard_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              weEff;
  logic              rsvEff;
  logic [ADDR_W-1:0] readAddr [NUM_R];

  // Qualify the write and reserve strobes. With a hardwired zero register,
  // anything aimed at address 0 is dropped here so neither the data array
  // nor the pending bits ever see it.
  always_comb begin
    weEff  = bus.we;
    rsvEff = bus.rsv;
    if (ZERO_REG != 0) begin
      if (bus.wa == '0) begin
        weEff = 1'b0;
      end
      if (bus.rsv_a == '0) begin
        rsvEff = 1'b0;
      end
    end
  end

  // Next pending state. The writeback clear is applied before the reserve
  // set, so a write and a reservation to the same register in one cycle
  // leave it pending: the newly issued producer wins.
  always_comb begin
    pend_d = pend_q;
    if (weEff) begin
      pend_d[bus.wa] = 1'b0;
    end
    if (rsvEff) begin
      pend_d[bus.rsv_a] = 1'b1;
    end
  end

  // Pending bit register; reset drops every outstanding producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Data array. Only the addressed entry is updated on a qualified write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (weEff) begin
      data_q[bus.wa] <= bus.wd;
    end
  end

  // Unpack the read addresses so each port can be resolved independently.
  always_comb begin
    for (int k = 0; k < NUM_R; k++) begin
      readAddr[k] = bus.ra[k*ADDR_W +: ADDR_W];
    end
  end

  // Read ports, resolved in priority order: zero register first, then the
  // same-cycle write bypass, then the stored entry. Outputs are forced to
  // zero while reset is held, so a write presented during reset cannot leak
  // through the bypass path.
  always_comb begin
    bus.rd      = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_R; k++) begin
      if (!rst_n) begin
        bus.rd[k*DATA_W +: DATA_W] = '0;
        bus.rd_busy[k]             = 1'b0;
      end else if ((ZERO_REG != 0) && (readAddr[k] == '0)) begin
        bus.rd[k*DATA_W +: DATA_W] = '0;
        bus.rd_busy[k]             = 1'b0;
      end else if ((WRITE_THROUGH != 0) && bus.we && (bus.wa == readAddr[k])) begin
        bus.rd[k*DATA_W +: DATA_W] = bus.wd;
        bus.rd_busy[k]             = 1'b0;
      end else begin
        bus.rd[k*DATA_W +: DATA_W] = data_q[readAddr[k]];
        bus.rd_busy[k]             = pend_q[readAddr[k]];
      end
    end
  end

  // Drain status comes straight from the registered pending bits; a
  // same-cycle writeback does not lower it until the following edge.
  assign bus.busy_any = |pend_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard
// Drives two register-file instances with the same stimulus:
//   dutA: NUM_R=4, ZERO_REG=1, WRITE_THROUGH=1
//   dutB: NUM_R=2, ZERO_REG=0, WRITE_THROUGH=0 (sees read ports 0 and 1)
// A reference model of each instance computes the expected reads when the
// stimulus is applied; they are queued and popped against the DUT outputs
// sampled mid-cycle.
module tb_rf_scoreboard;

  logic clk;
  logic rst_n;

  rf_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_R(4)) ifA ();
  rf_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_R(2)) ifB ();

  rf_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .NUM_R(4), .ZERO_REG(1), .WRITE_THROUGH(1)
  ) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA.slave)
  );

  rf_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .NUM_R(2), .ZERO_REG(0), .WRITE_THROUGH(0)
  ) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mDataA [32];
  logic [31:0] mDataB [32];
  logic [31:0] mPendA;
  logic [31:0] mPendB;
  logic        rstN;
  logic        curWe;
  logic [4:0]  curWa;
  logic [31:0] curWd;
  logic        curRsv;
  logic [4:0]  curRsvA;
  logic [4:0]  curRa [4];
  logic [31:0] expQ [$];
  int          checkCount;
  int          passCount;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected read data of one port, from the model state plus the inputs
  // currently presented.
  function automatic logic [31:0] expData(input bit isA, input logic [4:0] a);
    if (!rstN) return '0;
    if (isA && a == 5'd0) return '0;
    if (isA && curWe && curWa == a) return curWd;
    return isA ? mDataA[a] : mDataB[a];
  endfunction

  function automatic logic expBusy(input bit isA, input logic [4:0] a);
    if (!rstN) return 1'b0;
    if (isA && a == 5'd0) return 1'b0;
    if (isA && curWe && curWa == a) return 1'b0;
    return isA ? mPendA[a] : mPendB[a];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      mDataA[i] = '0;
      mDataB[i] = '0;
    end
    mPendA = '0;
    mPendB = '0;
  endtask

  // Clock-edge behaviour of both instances; A ignores address 0.
  task automatic updateModel();
    if (curWe && curWa != 5'd0) begin
      mDataA[curWa] = curWd;
      mPendA[curWa] = 1'b0;
    end
    if (curRsv && curRsvA != 5'd0) mPendA[curRsvA] = 1'b1;
    if (curWe) begin
      mDataB[curWa] = curWd;
      mPendB[curWa] = 1'b0;
    end
    if (curRsv) mPendB[curRsvA] = 1'b1;
  endtask

  task automatic driveInputs(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                             input logic r, input logic [4:0] ra,
                             input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3);
    curWe = w; curWa = wa; curWd = wd; curRsv = r; curRsvA = ra;
    curRa[0] = a0; curRa[1] = a1; curRa[2] = a2; curRa[3] = a3;
    ifA.we = w; ifA.wa = wa; ifA.wd = wd; ifA.rsv = r; ifA.rsv_a = ra;
    ifB.we = w; ifB.wa = wa; ifB.wd = wd; ifB.rsv = r; ifB.rsv_a = ra;
    ifA.ra = {a3, a2, a1, a0};
    ifB.ra = {a1, a0};
  endtask

  task automatic pushExpected();
    for (int k = 0; k < 4; k++) begin
      expQ.push_back(expData(1'b1, curRa[k]));
      expQ.push_back({31'b0, expBusy(1'b1, curRa[k])});
    end
    for (int k = 0; k < 2; k++) begin
      expQ.push_back(expData(1'b0, curRa[k]));
      expQ.push_back({31'b0, expBusy(1'b0, curRa[k])});
    end
    expQ.push_back({31'b0, rstN && (|mPendA)});
    expQ.push_back({31'b0, rstN && (|mPendB)});
  endtask

  // Pops the queued expectations in the order pushExpected produced them.
  task automatic compareCycle();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("A.rd%0d r%0d", k, curRa[k]), ifA.rd[k*32 +: 32], expQ.pop_front());
      checkOutput($sformatf("A.busy%0d r%0d", k, curRa[k]), {31'b0, ifA.rd_busy[k]}, expQ.pop_front());
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("B.rd%0d r%0d", k, curRa[k]), ifB.rd[k*32 +: 32], expQ.pop_front());
      checkOutput($sformatf("B.busy%0d r%0d", k, curRa[k]), {31'b0, ifB.rd_busy[k]}, expQ.pop_front());
    end
    checkOutput("A.busy_any", {31'b0, ifA.busy_any}, expQ.pop_front());
    checkOutput("B.busy_any", {31'b0, ifB.busy_any}, expQ.pop_front());
  endtask

  // One clock cycle: called 1 time unit after a rising edge, samples the
  // combinational outputs before the falling edge, then advances the model
  // on the next rising edge.
  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic r, input logic [4:0] ra,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] a3);
    driveInputs(w, wa, wd, r, ra, a0, a1, a2, a3);
    #3;
    pushExpected();
    compareCycle();
    @(posedge clk);
    if (rstN) updateModel();
    #1;
  endtask

  // Asynchronous reset between edges with a write and reserve pending;
  // both must be lost and the bypass must not show the write data.
  task automatic resetMidCycle();
    driveInputs(1'b1, 5'd5, 32'h0000_0077, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5);
    #2;
    rst_n = 1'b0;
    rstN  = 1'b0;
    clearModel();
    #1;
    pushExpected();
    compareCycle();
    @(posedge clk);
    #1;
    pushExpected();
    compareCycle();
    driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5);
    #2;
    rst_n = 1'b1;
    rstN  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n = 1'b0;
    rstN  = 1'b0;
    clearModel();
    driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    #3;
    pushExpected();
    compareCycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rstN  = 1'b1;

    // Fill r1/r2 and read them on all four ports (r1, r2, r1, r0).
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 5'd1, 5'd2, 5'd1, 5'd0);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 5'd1, 5'd2, 5'd1, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd1, 5'd2, 5'd1, 5'd0);

    // Same-cycle bypass on A, old value on B until the next edge.
    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd1, 5'd2, 5'd7);

    // Zero register: A ignores write and reserve of r0, B stores them.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    // Scoreboard: reserve r3, busy for three cycles, writeback, then clear.
    applyStimulus(1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 5'd2, 5'd3);
    end
    applyStimulus(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3);
    applyStimulus(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3);

    // Write and reserve the same register: data lands, pending stays set.
    applyStimulus(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 5'd9);

    // Write and reserve different registers in one cycle.
    applyStimulus(1'b1, 5'd9, 32'h66, 1'b1, 5'd10, 5'd9, 5'd10, 5'd9, 5'd10);
    applyStimulus(1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  5'd9, 5'd10, 5'd9, 5'd10);

    // Mid-operation asynchronous reset after storing 0xDEADBEEF in r5.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    applyStimulus(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5);
    resetMidCycle();
    applyStimulus(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd1, 5'd3, 5'd9);

    // Random traffic on a narrow address range to force overlaps.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file for the pipelined CPU datapath. It adds a configurable number of read ports, selectable data width and depth, and an optional hardwired zero register. It has write-through bypass, so a value written this cycle is visible on the read ports in the same cycle. A per-register pending (scoreboard) bit is set when the decode stage issues a producer and cleared on writeback; the hazard/redirect unit uses it to decide between forwarding and stalling. Writes occur on the rising edge; reads are combinational.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_R, 2, number of read ports
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
- WRITE_THROUGH, 1, 1 = same-cycle write data bypassed to matching read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ra  in  NUM_R*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd  out  NUM_R*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_R  1 = addressed register still has an outstanding producer
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- rsv  in  1  reserve: mark register rsv_a pending (producer issued)
- rsv_a  in  ADDR_W  reserve address
- busy_any  out  1  OR of all pending bits (drain/flush status)

## Operation
- State: data[0..2**ADDR_W-1] (DATA_W each) and pend[0..2**ADDR_W-1] (1 bit each).
- Reset (rst_n low, asynchronous): all data and all pend bits are cleared to 0. While reset is held: rd = 0 on every port, rd_busy = 0, busy_any = 0.
- Reset asserted mid-operation clears state immediately, regardless of clk; any we/rsv in that cycle is lost.
- Write: on a rising edge with we=1, data[wa] <= wd and pend[wa] <= 0.
- Reserve: on a rising edge with rsv=1, pend[rsv_a] <= 1.
- Write and reserve to the same address in the same cycle: data is written and pend ends at 1 (the new producer wins).
- Write and reserve to different addresses: both take effect.
- Read port k is combinational and evaluated in priority order (first match wins):
  - ZERO_REG=1 and ra_k=0: rd_k = 0, rd_busy_k = 0.
  - WRITE_THROUGH=1, we=1 and wa=ra_k: rd_k = wd, rd_busy_k = 0.
  - Otherwise: rd_k = data[ra_k], rd_busy_k = pend[ra_k].
- With WRITE_THROUGH=0 there is no bypass: rd_k = data[ra_k] and rd_busy_k = pend[ra_k]; the new value is visible from the next cycle.
- Reserve does not affect same-cycle reads; rd_busy rises in the cycle after rsv.
- ZERO_REG=1: writes and reservations to address 0 are ignored, so pend[0] stays 0.
- All read ports are independent; identical addresses on several ports return identical results.
- busy_any is the OR of the registered pend array; it is not bypassed.

## Timing
- Read latency is 0 cycles (combinational from ra, data, pend, and from we/wa/wd when WRITE_THROUGH=1).
- Write-to-read latency: 0 cycles with WRITE_THROUGH=1, 1 cycle with WRITE_THROUGH=0.
- Reserve-to-busy latency is 1 cycle. Writeback-to-not-busy latency is 0 cycles with bypass, 1 cycle without.
- No handshake: the caller guarantees that at most one write and one reservation are presented per cycle.
- There is no wrap-around; addresses cover the full depth.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n low asynchronously between clock edges. Required: rd for r5 reads 0 immediately, busy_any=0, and r5 reads 0 after release.
- Bypass: WRITE_THROUGH=1, we=1, wa=7, wd=0x12345678, ra port0=7. Required: rd0=0x12345678 in the same cycle. With WRITE_THROUGH=0, rd0 shows the old value until the next edge.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0. Required: rd=0, rd_busy=0, busy_any=0.
- Scoreboard: reserve r3 at cycle 0. Required: rd_busy=1 for r3 at cycles 1-3. Write r3=0xA5 at cycle 4. Required: with bypass, rd_busy=0 and rd=0xA5 at cycle 4; pend cleared at cycle 5.
- Same-cycle write and reserve: we and rsv both target r9, wd=0x55. Required: r9 reads 0x55 next cycle and rd_busy=1.
- NUM_R=4: all four ports read r1, r2, r1 and r0 with r1=0x11 and r2=0x22. Required: rd = 0x11, 0x22, 0x11, 0x0.
